// File: rtl/friscv_decoder_stage.sv
// RISC-V RV32I/RV64I decode stage: combinational decode of the incoming instruction
// into a DEPTH-entry FIFO of decoded words that the control unit drains.
module friscv_decoder_stage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            aclk,
  input  logic            srst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic [11:0]     out_csr,
  output logic [4:0]      out_zimm,
  output logic [5:0]      out_shamt,
  output logic            out_lui,
  output logic            out_auipc,
  output logic            out_jal,
  output logic            out_jalr,
  output logic            out_branch,
  output logic            out_load,
  output logic            out_store,
  output logic            out_fence,
  output logic            out_system,
  output logic            out_alu,
  output logic            out_word,
  output logic            out_error
);

  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW   = AW + 1;
  localparam bit IS64 = (XLEN == 64);

  // cls bit order: lui, auipc, jal, jalr, branch, load, store, fence, system, alu, word
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [11:0]     csr;
    logic [4:0]      zimm;
    logic [5:0]      shamt;
    logic [10:0]     cls;
    logic            error;
  } entry_t;

  function automatic logic [31:0] imm_i(input logic [31:0] i);
    return {{20{i[31]}}, i[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] i);
    return {{20{i[31]}}, i[31:25], i[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] i);
    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] i);
    return {i[31:12], 12'd0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] i);
    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
  endfunction

  // wide6 selects the RV64 OP-IMM shift layout (6-bit shamt, SRAI pattern 6'h10)
  function automatic logic shift_bad(input logic [31:0] i, input logic wide6);
    logic bad;
    bad = 1'b0;
    if (i[14:12] == 3'd1) begin
      if (wide6) bad = (i[31:26] != 6'd0);
      else       bad = (i[31:25] != 7'd0);
    end else if (i[14:12] == 3'd5) begin
      if (wide6) bad = (i[31:26] != 6'd0) && (i[31:26] != 6'h10);
      else       bad = (i[31:25] != 7'd0) && (i[31:25] != 7'h20);
    end else begin
      bad = 1'b0;
    end
    return bad;
  endfunction

  function automatic logic op_bad(input logic [31:0] i);
    logic bad;
    if (i[31:25] == 7'h00)      bad = 1'b0;
    else if (i[31:25] == 7'h20) bad = !((i[14:12] == 3'd0) || (i[14:12] == 3'd5));
    else                        bad = 1'b1;
    return bad;
  endfunction

  entry_t          mem_q [DEPTH];
  entry_t          dec_s;
  entry_t          head_s;
  logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [31:0]     imm32_s;
  logic [10:0]     cls_s;
  logic            bad_s, unk_s, err_s;
  logic            full_s, empty_s, push_s, pop_s;

  // Combinational decode of in_instr into a FIFO entry
  always_comb begin
    imm32_s = 32'd0;
    cls_s   = 11'd0;
    bad_s   = 1'b0;
    unk_s   = 1'b0;
    case (in_instr[6:0])
      7'h37: begin cls_s[10] = 1'b1; imm32_s = imm_u(in_instr); end
      7'h17: begin cls_s[9]  = 1'b1; imm32_s = imm_u(in_instr); end
      7'h6F: begin cls_s[8]  = 1'b1; imm32_s = imm_j(in_instr); end
      7'h67: begin
        cls_s[7] = 1'b1; imm32_s = imm_i(in_instr);
        bad_s = (in_instr[14:12] != 3'd0);
      end
      7'h63: begin
        cls_s[6] = 1'b1; imm32_s = imm_b(in_instr);
        bad_s = (in_instr[14:12] == 3'd2) || (in_instr[14:12] == 3'd3);
      end
      7'h03: begin
        cls_s[5] = 1'b1; imm32_s = imm_i(in_instr);
        if (IS64) bad_s = (in_instr[14:12] == 3'd7);
        else      bad_s = (in_instr[14:12] > 3'd5) || (in_instr[14:12] == 3'd3);
      end
      7'h23: begin
        cls_s[4] = 1'b1; imm32_s = imm_s(in_instr);
        if (IS64) bad_s = (in_instr[14:12] > 3'd3);
        else      bad_s = (in_instr[14:12] > 3'd2);
      end
      7'h0F: begin cls_s[3] = 1'b1; imm32_s = imm_i(in_instr); end
      7'h73: begin cls_s[2] = 1'b1; imm32_s = imm_i(in_instr); end
      7'h13: begin
        cls_s[1] = 1'b1; imm32_s = imm_i(in_instr);
        bad_s = shift_bad(in_instr, IS64);
      end
      7'h33: begin cls_s[1] = 1'b1; bad_s = op_bad(in_instr); end
      7'h1B: begin
        cls_s[1] = 1'b1; cls_s[0] = 1'b1; imm32_s = imm_i(in_instr);
        if (IS64) bad_s = shift_bad(in_instr, 1'b0);
        else      bad_s = 1'b1;
      end
      7'h3B: begin
        cls_s[1] = 1'b1; cls_s[0] = 1'b1;
        if (IS64) bad_s = op_bad(in_instr);
        else      bad_s = 1'b1;
      end
      default: unk_s = 1'b1;
    endcase
    err_s = (in_instr[1:0] != 2'b11) || unk_s || bad_s;

    dec_s        = '0;
    dec_s.pc     = in_pc;
    dec_s.opcode = in_instr[6:0];
    dec_s.funct3 = in_instr[14:12];
    dec_s.funct7 = in_instr[31:25];
    dec_s.rs1    = in_instr[19:15];
    dec_s.rs2    = in_instr[24:20];
    dec_s.rd     = in_instr[11:7];
    dec_s.imm    = XLEN'($signed(imm32_s));
    dec_s.csr    = in_instr[31:20];
    dec_s.zimm   = in_instr[19:15];
    if (IS64) dec_s.shamt = in_instr[25:20];
    else      dec_s.shamt = {1'b0, in_instr[24:20]};
    if (err_s) dec_s.cls = 11'd0;
    else       dec_s.cls = cls_s;
    dec_s.error  = err_s;
  end

  assign full_s  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[PW-1] != rptr_q[PW-1]);
  assign empty_s = (wptr_q == rptr_q);
  assign push_s  = in_valid && !full_s && !flush;
  assign pop_s   = out_ready && !empty_s && !flush;

  // Pointer next-state
  always_comb begin
    if (push_s) wptr_d = wptr_q + PW'(1);
    else        wptr_d = wptr_q;
    if (pop_s)  rptr_d = rptr_q + PW'(1);
    else        rptr_d = rptr_q;
  end

  // FIFO storage; reset clears contents so every output reads zero, flush only rewinds
  always_ff @(posedge aclk) begin
    if (srst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
    end else if (flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_s) mem_q[wptr_q[AW-1:0]] <= dec_s;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  assign head_s     = mem_q[rptr_q[AW-1:0]];
  assign in_ready   = !full_s;
  assign out_valid  = !empty_s;
  assign out_pc     = head_s.pc;
  assign out_opcode = head_s.opcode;
  assign out_funct3 = head_s.funct3;
  assign out_funct7 = head_s.funct7;
  assign out_rs1    = head_s.rs1;
  assign out_rs2    = head_s.rs2;
  assign out_rd     = head_s.rd;
  assign out_imm    = head_s.imm;
  assign out_csr    = head_s.csr;
  assign out_zimm   = head_s.zimm;
  assign out_shamt  = head_s.shamt;
  assign out_lui    = head_s.cls[10];
  assign out_auipc  = head_s.cls[9];
  assign out_jal    = head_s.cls[8];
  assign out_jalr   = head_s.cls[7];
  assign out_branch = head_s.cls[6];
  assign out_load   = head_s.cls[5];
  assign out_store  = head_s.cls[4];
  assign out_fence  = head_s.cls[3];
  assign out_system = head_s.cls[2];
  assign out_alu    = head_s.cls[1];
  assign out_word   = head_s.cls[0];
  assign out_error  = head_s.error;

endmodule

// File: tb/tb_friscv_decoder_stage.sv
// Scoreboard bench for friscv_decoder_stage: an RV32 instance (stream, backpressure,
// flush, reset) and an RV64 instance (W-opcodes, 6-bit shamt, 64-bit sign extension).
module tb_friscv_decoder_stage;

  localparam int DEPTH = 2;
  localparam logic [11:0] F_LUI = 12'h800, F_AUIPC = 12'h400, F_JAL = 12'h200, F_JALR = 12'h100,
                          F_BR  = 12'h080, F_LD    = 12'h040, F_ST  = 12'h020, F_FEN  = 12'h010,
                          F_SYS = 12'h008, F_ALU   = 12'h004, F_W   = 12'h002, F_ERR  = 12'h001;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] imm;
    logic        chk_imm;
    logic [11:0] flags;
    logic [31:0] instr;
  } exp_t;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic srst, flush;

  // RV32 instance signals
  logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a;
  logic [31:0] in_instr_a, in_pc_a, out_pc_a, out_imm_a;
  logic [6:0]  out_opcode_a, out_funct7_a;
  logic [2:0]  out_funct3_a;
  logic [4:0]  out_rs1_a, out_rs2_a, out_rd_a, out_zimm_a;
  logic [11:0] out_csr_a, flags_a;
  logic [5:0]  out_shamt_a;
  logic out_lui_a, out_auipc_a, out_jal_a, out_jalr_a, out_branch_a, out_load_a;
  logic out_store_a, out_fence_a, out_system_a, out_alu_a, out_word_a, out_error_a;

  // RV64 instance signals
  logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b;
  logic [31:0] in_instr_b;
  logic [63:0] in_pc_b, out_pc_b, out_imm_b;
  logic [6:0]  out_opcode_b, out_funct7_b;
  logic [2:0]  out_funct3_b;
  logic [4:0]  out_rs1_b, out_rs2_b, out_rd_b, out_zimm_b;
  logic [11:0] out_csr_b, flags_b;
  logic [5:0]  out_shamt_b;
  logic out_lui_b, out_auipc_b, out_jal_b, out_jalr_b, out_branch_b, out_load_b;
  logic out_store_b, out_fence_b, out_system_b, out_alu_b, out_word_b, out_error_b;

  assign flags_a = {out_lui_a, out_auipc_a, out_jal_a, out_jalr_a, out_branch_a, out_load_a,
                    out_store_a, out_fence_a, out_system_a, out_alu_a, out_word_a, out_error_a};
  assign flags_b = {out_lui_b, out_auipc_b, out_jal_b, out_jalr_b, out_branch_b, out_load_b,
                    out_store_b, out_fence_b, out_system_b, out_alu_b, out_word_b, out_error_b};

  friscv_decoder_stage #(.XLEN(32), .DEPTH(DEPTH)) dut32 (
    .aclk(aclk), .srst(srst), .flush(flush),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_instr(in_instr_a), .in_pc(in_pc_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_pc(out_pc_a),
    .out_opcode(out_opcode_a), .out_funct3(out_funct3_a), .out_funct7(out_funct7_a),
    .out_rs1(out_rs1_a), .out_rs2(out_rs2_a), .out_rd(out_rd_a), .out_imm(out_imm_a),
    .out_csr(out_csr_a), .out_zimm(out_zimm_a), .out_shamt(out_shamt_a),
    .out_lui(out_lui_a), .out_auipc(out_auipc_a), .out_jal(out_jal_a), .out_jalr(out_jalr_a),
    .out_branch(out_branch_a), .out_load(out_load_a), .out_store(out_store_a),
    .out_fence(out_fence_a), .out_system(out_system_a), .out_alu(out_alu_a),
    .out_word(out_word_a), .out_error(out_error_a)
  );

  friscv_decoder_stage #(.XLEN(64), .DEPTH(DEPTH)) dut64 (
    .aclk(aclk), .srst(srst), .flush(flush),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_instr(in_instr_b), .in_pc(in_pc_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_pc(out_pc_b),
    .out_opcode(out_opcode_b), .out_funct3(out_funct3_b), .out_funct7(out_funct7_b),
    .out_rs1(out_rs1_b), .out_rs2(out_rs2_b), .out_rd(out_rd_b), .out_imm(out_imm_b),
    .out_csr(out_csr_b), .out_zimm(out_zimm_b), .out_shamt(out_shamt_b),
    .out_lui(out_lui_b), .out_auipc(out_auipc_b), .out_jal(out_jal_b), .out_jalr(out_jalr_b),
    .out_branch(out_branch_b), .out_load(out_load_b), .out_store(out_store_b),
    .out_fence(out_fence_b), .out_system(out_system_b), .out_alu(out_alu_b),
    .out_word(out_word_b), .out_error(out_error_b)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q32[$];
  exp_t q64[$];
  exp_t pend32;
  exp_t e64;
  logic acc_s;

  logic [31:0] t_instr [19];
  logic [63:0] t_imm   [19];
  logic        t_ci    [19];
  logic [11:0] t_fl    [19];
  logic [31:0] u_instr [9];
  logic [63:0] u_imm   [9];
  logic [11:0] u_fl    [9];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic cmp_entry(input string dut, input exp_t e, input logic is64,
                           input logic [63:0] pc, input logic [63:0] imm, input logic [11:0] fl,
                           input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [5:0] sh);
    string t;
    logic [5:0] esh;
    t   = $sformatf("%s.%08h", dut, e.instr);
    esh = is64 ? e.instr[25:20] : {1'b0, e.instr[24:20]};
    chk({t, ".pc"}, pc, e.pc);
    chk({t, ".flags"}, {52'd0, fl}, {52'd0, e.flags});
    if (e.chk_imm) chk({t, ".imm"}, imm, e.imm);
    chk({t, ".opcode"}, {57'd0, op}, {57'd0, e.instr[6:0]});
    chk({t, ".funct3"}, {61'd0, f3}, {61'd0, e.instr[14:12]});
    chk({t, ".rd"}, {59'd0, rd}, {59'd0, e.instr[11:7]});
    chk({t, ".rs1"}, {59'd0, rs1}, {59'd0, e.instr[19:15]});
    chk({t, ".rs2"}, {59'd0, rs2}, {59'd0, e.instr[24:20]});
    chk({t, ".shamt"}, {58'd0, sh}, {58'd0, esh});
  endtask

  task automatic drive32(input int k);
    in_valid_a = 1'b1;
    in_instr_a = t_instr[k];
    in_pc_a    = 32'h100 + 32'(4 * k);
    pend32     = '{pc: 64'h100 + 64'(4 * k), imm: t_imm[k], chk_imm: t_ci[k],
                   flags: t_fl[k], instr: t_instr[k]};
  endtask

  // One RV32 cycle: check handshake state against the model, score the edge, advance
  task automatic cycle32();
    exp_t e;
    chk("x32.out_valid", {63'd0, out_valid_a}, {63'd0, q32.size() != 0});
    chk("x32.in_ready", {63'd0, in_ready_a}, {63'd0, q32.size() < DEPTH});
    if (srst || flush) begin
      q32.delete();
    end else begin
      if (out_valid_a && out_ready_a && q32.size() > 0) begin
        e = q32.pop_front();
        cmp_entry("x32", e, 1'b0, {32'd0, out_pc_a}, {32'd0, out_imm_a}, flags_a, out_opcode_a,
                  out_funct3_a, out_rd_a, out_rs1_a, out_rs2_a, out_shamt_a);
      end
      if (in_valid_a && in_ready_a) q32.push_back(pend32);
    end
    @(negedge aclk);
  endtask

  task automatic drain32();
    in_valid_a  = 1'b0;
    out_ready_a = 1'b1;
    for (int k = 0; k < 8 && q32.size() > 0; k++) cycle32();
    chk("x32.drain_left", 64'(q32.size()), 64'd0);
    cycle32();
    cycle32();
  endtask

  task automatic chk_zero32(input string tag);
    chk({tag, ".out_valid"}, {63'd0, out_valid_a}, 64'd0);
    chk({tag, ".in_ready"}, {63'd0, in_ready_a}, 64'd1);
    chk({tag, ".pc"}, {32'd0, out_pc_a}, 64'd0);
    chk({tag, ".imm"}, {32'd0, out_imm_a}, 64'd0);
    chk({tag, ".flags"}, {52'd0, flags_a}, 64'd0);
    chk({tag, ".fields"}, {9'd0, out_opcode_a, out_funct3_a, out_funct7_a, out_rs1_a, out_rs2_a,
                           out_rd_a, out_csr_a, out_zimm_a, out_shamt_a}, 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    t_instr = '{32'h00C12403, 32'hFE000EE3, 32'h800000EF, 32'hFFFFF0B7, 32'h00000000,
                32'h40001033, 32'h0000001B, 32'h03F09093, 32'h00512423, 32'h12345097,
                32'hFFF00093, 32'h00008067, 32'h4030D093, 32'h00003003, 32'h00000073,
                32'h0FF0000F, 32'h40000033, 32'h00003023, 32'h00009067};
    t_imm   = '{64'h0C, 64'hFFFFFFFC, 64'hFFF00000, 64'hFFFFF000, 64'h0,
                64'h0, 64'h0, 64'h0, 64'h8, 64'h12345000,
                64'hFFFFFFFF, 64'h0, 64'h403, 64'h0, 64'h0,
                64'h0, 64'h0, 64'h0, 64'h0};
    t_ci    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1,
                1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    t_fl    = '{F_LD, F_BR, F_JAL, F_LUI, F_ERR, F_ERR, F_ERR, F_ERR, F_ST, F_AUIPC,
                F_ALU, F_JALR, F_ALU, F_ERR, F_SYS, F_FEN, F_ALU, F_ERR, F_ERR};
    u_instr = '{32'h03F09093, 32'h0000003B, 32'h0000B003, 32'h4000D093, 32'hFFF00093,
                32'hFFFFF0B7, 32'h00007003, 32'h40001033, 32'hFE000EE3};
    u_imm   = '{64'h3F, 64'h0, 64'h0, 64'h400, 64'hFFFFFFFFFFFFFFFF,
                64'hFFFFFFFFFFFFF000, 64'h0, 64'h0, 64'hFFFFFFFFFFFFFFFC};
    u_fl    = '{F_ALU, F_ALU | F_W, F_LD, F_ALU, F_ALU, F_LUI, F_ERR, F_ERR, F_BR};

    srst = 1'b1; flush = 1'b0;
    in_valid_a = 1'b0; in_instr_a = 32'd0; in_pc_a = 32'd0; out_ready_a = 1'b0;
    in_valid_b = 1'b0; in_instr_b = 32'd0; in_pc_b = 64'd0; out_ready_b = 1'b1;
    acc_s = 1'b0;
    repeat (3) @(negedge aclk);
    srst = 1'b0;
    chk_zero32("reset");

    // Continuous stream with the consumer always ready
    out_ready_a = 1'b1;
    for (int k = 0; k < 19; k++) begin
      drive32(k);
      cycle32();
    end
    drain32();

    // Backpressure: consumer stalled, third instruction held until space appears
    out_ready_a = 1'b0;
    drive32(0); cycle32();
    drive32(1); cycle32();
    drive32(2);
    chk("bp.in_ready_full", {63'd0, in_ready_a}, 64'd0);
    repeat (3) cycle32();
    out_ready_a = 1'b1;
    for (int k = 0; k < 6; k++) begin
      acc_s = in_valid_a && in_ready_a;
      cycle32();
      if (acc_s) in_valid_a = 1'b0;
    end
    chk("bp.third_accepted", {63'd0, in_valid_a}, 64'd0);
    drain32();

    // Flush while full, with a new instruction offered in the flush cycle
    out_ready_a = 1'b0;
    drive32(1); cycle32();
    drive32(2); cycle32();
    drive32(3);
    flush = 1'b1;
    cycle32();
    flush = 1'b0;
    in_valid_a = 1'b0;
    chk("flush.out_valid", {63'd0, out_valid_a}, 64'd0);
    chk("flush.in_ready", {63'd0, in_ready_a}, 64'd1);
    repeat (2) cycle32();
    out_ready_a = 1'b1;
    drive32(9); cycle32();
    drain32();

    // Reset mid-burst, together with flush, must zero every output
    out_ready_a = 1'b0;
    drive32(0); cycle32();
    drive32(3); cycle32();
    drive32(8);
    srst  = 1'b1;
    flush = 1'b1;
    cycle32();
    srst  = 1'b0;
    flush = 1'b0;
    in_valid_a = 1'b0;
    chk_zero32("srst");
    repeat (2) cycle32();

    // RV64 instance: one instruction at a time through the scoreboard
    for (int k = 0; k < 9; k++) begin
      in_valid_b = 1'b1;
      in_instr_b = u_instr[k];
      in_pc_b    = 64'h8000_0000_0000_1000 + 64'(4 * k);
      chk("x64.in_ready", {63'd0, in_ready_b}, 64'd1);
      q64.push_back('{pc: 64'h8000_0000_0000_1000 + 64'(4 * k), imm: u_imm[k], chk_imm: 1'b1,
                      flags: u_fl[k], instr: u_instr[k]});
      @(negedge aclk);
      in_valid_b = 1'b0;
      chk("x64.latency", {63'd0, out_valid_b}, 64'd1);
      if (out_valid_b && q64.size() > 0) begin
        e64 = q64.pop_front();
        cmp_entry("x64", e64, 1'b1, out_pc_b, out_imm_b, flags_b, out_opcode_b, out_funct3_b,
                  out_rd_b, out_rs1_b, out_rs2_b, out_shamt_b);
      end
      @(negedge aclk);
      chk("x64.popped", {63'd0, out_valid_b}, 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/friscv_decoder_stage.md
# friscv_decoder_stage

Registered, buffered RISC-V instruction decode stage, parametrised for RV32I or RV64I. It accepts fetched instructions with their PC over a valid/ready handshake, decodes them into register indexes, a sign-extended immediate, instruction-class flags and an illegal-instruction flag, and queues the results in a DEPTH-entry FIFO. The control unit drains the FIFO. The block sits between the instruction fetch path and the control/dispatch unit, and adds a flush for branch redirects.

## Interface
- XLEN, 32: data width; legal values 32 or 64. 64 enables the RV64I W-opcodes and 6-bit shamt.
- DEPTH, 2: number of decoded-instruction FIFO entries; power of two, at least 2.
- aclk  in  1  clock.
- srst  in  1  synchronous active-high reset.
- flush  in  1  drops all buffered entries; input is ignored in the same cycle.
- in_valid  in  1  instruction/PC valid.
- in_ready  out  1  stage can accept; equals !full.
- in_instr  in  32  raw instruction.
- in_pc  in  XLEN  instruction address.
- out_valid  out  1  FIFO head valid; equals !empty.
- out_ready  in  1  consumer accepts the head.
- out_pc  out  XLEN  PC of the head entry.
- out_opcode, out_funct3, out_funct7  out  7/3/7  raw fields.
- out_rs1, out_rs2, out_rd  out  5 each  register indexes.
- out_imm  out  XLEN  format-selected, sign-extended immediate.
- out_csr  out  12  instr[31:20].
- out_zimm  out  5  instr[19:15].
- out_shamt  out  6  instr[25:20]; bit 5 is forced to 0 when XLEN=32.
- out_lui, out_auipc, out_jal, out_jalr, out_branch, out_load, out_store, out_fence, out_system, out_alu, out_word  out  1 each  class flags; exactly one of the first ten is set unless out_error is set. out_word marks OP-IMM-32/OP-32.
- out_error  out  1  illegal instruction; when set, all class flags are 0.

## Operation
- Decode is combinational on in_instr. The decoded word and in_pc are written into the FIFO when in_valid && in_ready && !flush.
- Immediate formats:
  - I: sext(i[31:20]).
  - S: sext({i[31:25], i[11:7]}).
  - B: sext({i[31], i[7], i[30:25], i[11:8], 1'b0}).
  - U: sext({i[31:12], 12'b0}).
  - J: sext({i[31], i[19:12], i[20], i[30:21], 1'b0}).
  - Any other opcode: out_imm = 0.
- Opcode classes:
  - 0x37 lui, 0x17 auipc, 0x6F jal, 0x67 jalr (requires funct3=0).
  - 0x63 branch (funct3 not in {2,3}).
  - 0x03 load: funct3 ≤ 5 for XLEN=32; ≤ 6 for XLEN=64, excluding 3 when XLEN=32.
  - 0x23 store: funct3 ≤ 2, or ≤ 3 when XLEN=64.
  - 0x0F fence, 0x73 system, 0x13/0x33 alu.
  - 0x1B/0x3B alu with out_word=1, XLEN=64 only.
- out_error is set when any of these hold:
  - instr[1:0] != 2'b11.
  - Opcode is outside the list above, or violates its funct3 constraint.
  - OP (0x33) with funct7 not 0x00, or funct7=0x20 with funct3 not in {0,5}.
  - Shift-immediate with nonzero upper bits: instr[31:25] for XLEN=32; instr[31:26] for XLEN=64, except the 0x10 pattern for SRAI.
  - A W-opcode when XLEN=32.
- Illegal instructions still occupy a FIFO entry, so that a trap is raised with the correct PC.
- FIFO behaviour:
  - Write and read pointers are log2(DEPTH)+1 bits; wrap-around uses the MSB compare.
  - A pop happens when out_valid && out_ready.
  - Push and pop in the same cycle are legal when not full; the count is unchanged. When full, no push can occur because in_ready=0.
  - Read-through is not allowed: an entry written in cycle N is visible at N+1.
- flush: the next cycle has empty FIFO, pointers at 0 and in_ready=1. Any push or pop in the flush cycle is discarded.
- Stored outputs are driven straight from the head entry. Output fields are only meaningful while out_valid=1.

## Timing
- Latency is 1 cycle from the accepting edge to out_valid=1.
- Throughput is 1 instruction per cycle under continuous out_ready.
- in_ready depends only on registered state, with no combinational path from out_ready.
- srst, synchronous and dominant over flush: pointers are cleared, out_valid=0, in_ready=1 and all FIFO entries are zeroed, so every out_* reads 0. It takes effect on the next aclk edge, including mid-burst; in-flight entries are lost.
- Holding in_valid with in_ready=0 must not drop or duplicate the instruction.

## Test plan
- XLEN=32, in_instr=0x00C12403, pc=0x100 -> next cycle out_valid=1, opcode=0x03, rd=8, rs1=2, funct3=2, imm=12, out_load=1, out_error=0, out_pc=0x100.
- Backpressure: DEPTH=2, out_ready=0, push 3 instructions -> in_ready=0 after the 2nd is accepted; after out_ready=1, pops occur in order and the 3rd instruction is accepted exactly once.
- Immediate formats: 0xFE000EE3 (beq x0,x0,-4) -> imm=0xFFFFFFFC, out_branch=1; 0x800000EF (jal) -> imm=0xFFF00000; 0xFFFFF0B7 (lui) -> imm=0xFFFFF000.
- Illegal cases: 0x00000000 -> out_error=1 with all class flags 0; 0x4000_1033 (funct7=0x20, funct3=1) -> out_error=1; 0x0000001B with XLEN=32 -> out_error=1.
- XLEN=64: 0x03F09093 (slli x1,x1,63) -> shamt=63, out_alu=1, out_error=0; 0x0000003B (addw) -> out_word=1. The same slli with XLEN=32 -> out_error=1.
- Flush and reset: fill the FIFO, assert flush together with in_valid -> next cycle out_valid=0, in_ready=1, and the flushed-cycle instruction is absent. Assert srst mid-burst -> all outputs are 0 on the following cycle.
